// File: rtl/march_program_sequencer.sv
// March program store and issue sequencer feeding the memory BIST scan/test-start interface.
// Optional per-element watchdog is enabled by defining MPL_ELEM_TIMEOUT_EN (adds parameter tw, port timeout_out).
//
// state  | meaning
// IDLE   | program loadable, waiting for start
// ISSUE  | one cycle: register mem[rd] onto scan_out and raise ts_out
// WAIT   | element running in BIST; collect passfail, wait for elem_done
// DONE   | run finished; program loadable, start re-runs
module march_program_sequencer #(
    parameter int sw    = 16,
    parameter int depth = 8,
    parameter int pw    = 3
`ifdef MPL_ELEM_TIMEOUT_EN
    ,
    parameter int tw    = 12
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sdi_in,
    input  logic          shift_in,
    input  logic          commit_in,
    input  logic          clear_in,
    input  logic          start_in,
    input  logic          elem_done_in,
    input  logic          passfail_in,
    output logic [sw-1:0] scan_out,
    output logic          ts_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          fail_out,
    output logic [pw:0]   count_out
`ifdef MPL_ELEM_TIMEOUT_EN
    ,
    output logic          timeout_out
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [pw:0] CNT_MAX = (pw+1)'(depth);

    state_t        r_state;
    logic [sw-1:0] r_shreg;
    logic [sw-1:0] r_scan;
    logic [sw-1:0] r_mem [depth];
    logic [pw:0]   r_count;
    logic [pw-1:0] r_rd;
    logic          r_ts;
    logic          r_fail;

    logic          w_load_ok;
    logic          w_commit;
    logic          w_last;
    logic [sw-1:0] w_shreg_next;

`ifdef MPL_ELEM_TIMEOUT_EN
    // Leave WAIT on the cycle the watchdog would step onto all-ones.
    localparam logic [tw-1:0] WD_LAST = tw'((1 << tw) - 2);
    logic [tw-1:0] r_wdog;
    logic          r_timeout;
    assign timeout_out = r_timeout;
`endif

    assign w_load_ok    = !clear_in && (r_state == S_IDLE || r_state == S_DONE);
    assign w_shreg_next = shift_in ? {r_shreg[sw-2:0], sdi_in} : r_shreg;
    assign w_commit     = w_load_ok && commit_in && (r_count < CNT_MAX);
    assign w_last       = ({1'b0, r_rd} == (r_count - 1'b1));

    assign scan_out  = r_scan;
    assign ts_out    = r_ts;
    assign busy_out  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign done_out  = (r_state == S_DONE);
    assign fail_out  = r_fail;
    assign count_out = r_count;

    // Program store has no reset; commit writes the post-shift word.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_count[pw-1:0]] <= w_shreg_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_scan    <= '0;
            r_count   <= '0;
            r_rd      <= '0;
            r_ts      <= 1'b0;
            r_fail    <= 1'b0;
`ifdef MPL_ELEM_TIMEOUT_EN
            r_wdog    <= '0;
            r_timeout <= 1'b0;
`endif
        end else if (clear_in) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rd      <= '0;
            r_ts      <= 1'b0;
`ifdef MPL_ELEM_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            r_ts <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (shift_in) begin
                        r_shreg <= w_shreg_next;
                    end
                    if (w_commit) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (start_in) begin
                        r_fail  <= 1'b0;
                        r_rd    <= '0;
                        r_state <= (r_count != '0) ? S_ISSUE : S_DONE;
`ifdef MPL_ELEM_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    r_scan  <= r_mem[r_rd];
                    r_ts    <= 1'b1;
                    r_state <= S_WAIT;
`ifdef MPL_ELEM_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                end
                S_WAIT: begin
                    if (passfail_in) begin
                        r_fail <= 1'b1;
                    end
                    if (elem_done_in) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_rd    <= r_rd + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
`ifdef MPL_ELEM_TIMEOUT_EN
                    else if (r_wdog == WD_LAST) begin
                        r_state   <= S_DONE;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_march_program_sequencer.sv
// Directed bench for march_program_sequencer: load, issue order, saturation, sticky fail, abort paths.
// Define MPL_ELEM_TIMEOUT_EN to also exercise the watchdog with tw = 4.
module tb_march_program_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sdi_in = 1'b0;
    logic        shift_in = 1'b0;
    logic        commit_in = 1'b0;
    logic        clear_in = 1'b0;
    logic        start_in = 1'b0;
    logic        elem_done_in = 1'b0;
    logic        passfail_in = 1'b0;
    logic [15:0] scan_out;
    logic        ts_out;
    logic        busy_out;
    logic        done_out;
    logic        fail_out;
    logic [3:0]  count_out;
`ifdef MPL_ELEM_TIMEOUT_EN
    logic        timeout_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    march_program_sequencer #(
        .sw(16), .depth(8), .pw(3)
`ifdef MPL_ELEM_TIMEOUT_EN
        , .tw(4)
`endif
    ) dut (
        .clk(clk), .rst(rst), .sdi_in(sdi_in), .shift_in(shift_in),
        .commit_in(commit_in), .clear_in(clear_in), .start_in(start_in),
        .elem_done_in(elem_done_in), .passfail_in(passfail_in),
        .scan_out(scan_out), .ts_out(ts_out), .busy_out(busy_out),
        .done_out(done_out), .fail_out(fail_out), .count_out(count_out)
`ifdef MPL_ELEM_TIMEOUT_EN
        , .timeout_out(timeout_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            sdi_in   = w[i];
            shift_in = 1'b1;
            tick();
        end
        shift_in = 1'b0;
        sdi_in   = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        shift_word(w);
        commit_in = 1'b1;
        tick();
        commit_in = 1'b0;
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({scan_out, ts_out, busy_out, done_out, fail_out, count_out} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_outputs got scan=%h ts=%b busy=%b done=%b fail=%b cnt=%0d want all 0",
                     scan_out, ts_out, busy_out, done_out, fail_out, count_out);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        load_word(16'hA5C3);
        n_vec++;
        if (count_out !== 4'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count_out); end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_vec++;
        if (busy_out !== 1'b1 || ts_out !== 1'b0) begin
            n_err++; $display("FAIL single_issue got busy=%b ts=%b want busy=1 ts=0", busy_out, ts_out);
        end
        tick();
        n_vec++;
        if (ts_out !== 1'b1 || scan_out !== 16'hA5C3) begin
            n_err++; $display("FAIL single_ts got ts=%b scan=%h want ts=1 scan=a5c3", ts_out, scan_out);
        end
        elem_done_in = 1'b1;
        tick();
        elem_done_in = 1'b0;
        n_vec++;
        if (done_out !== 1'b1 || fail_out !== 1'b0 || busy_out !== 1'b0 || ts_out !== 1'b0) begin
            n_err++; $display("FAIL single_done got done=%b fail=%b busy=%b ts=%b want 1 0 0 0",
                              done_out, fail_out, busy_out, ts_out);
        end
    endtask

    task automatic test_multi_order();
        do_clear();
        for (int k = 1; k <= 3; k++) load_word(16'(k));
        n_vec++;
        if (count_out !== 4'd3) begin n_err++; $display("FAIL multi_count got %0d want 3", count_out); end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_vec++;
            if (ts_out !== 1'b1 || scan_out !== 16'(e + 1)) begin
                n_err++; $display("FAIL multi_issue%0d got ts=%b scan=%h want ts=1 scan=%h", e, ts_out, scan_out, 16'(e + 1));
            end
            for (int c = 0; c < 5; c++) tick();
            n_vec++;
            if (ts_out !== 1'b0 || busy_out !== 1'b1 || scan_out !== 16'(e + 1)) begin
                n_err++; $display("FAIL multi_wait%0d got ts=%b busy=%b scan=%h want 0 1 %h", e, ts_out, busy_out, scan_out, 16'(e + 1));
            end
            elem_done_in = 1'b1;
            tick();
            elem_done_in = 1'b0;
        end
        n_vec++;
        if (done_out !== 1'b1 || fail_out !== 1'b0) begin
            n_err++; $display("FAIL multi_done got done=%b fail=%b want 1 0", done_out, fail_out);
        end
    endtask

    task automatic test_overflow_empty();
        do_clear();
        for (int k = 0; k < 9; k++) load_word(16'h1000 + 16'(k));
        n_vec++;
        if (count_out !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count_out); end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            n_vec++;
            if (ts_out !== 1'b1 || scan_out !== 16'h1000 + 16'(e)) begin
                n_err++; $display("FAIL ovf_word%0d got ts=%b scan=%h want ts=1 scan=%h", e, ts_out, scan_out, 16'h1000 + 16'(e));
            end
            elem_done_in = 1'b1;
            tick();
            elem_done_in = 1'b0;
        end
        n_vec++;
        if (done_out !== 1'b1) begin n_err++; $display("FAIL ovf_done got %b want 1", done_out); end
        do_clear();
        n_vec++;
        if (count_out !== 4'd0 || done_out !== 1'b0) begin
            n_err++; $display("FAIL empty_clear got cnt=%0d done=%b want 0 0", count_out, done_out);
        end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_vec++;
        if (done_out !== 1'b1 || ts_out !== 1'b0 || busy_out !== 1'b0) begin
            n_err++; $display("FAIL empty_done got done=%b ts=%b busy=%b want 1 0 0", done_out, ts_out, busy_out);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++;
            if (ts_out !== 1'b0) begin n_err++; $display("FAIL empty_no_ts got ts=%b want 0", ts_out); end
        end
    endtask

    task automatic test_sticky_fail();
        do_clear();
        load_word(16'h0011);
        load_word(16'h0022);
        load_word(16'h0033);
        for (int run = 0; run < 2; run++) begin
            start_in = 1'b1;
            tick();
            start_in = 1'b0;
            n_vec++;
            if (fail_out !== 1'b0) begin n_err++; $display("FAIL sticky_start%0d got fail=%b want 0", run, fail_out); end
            for (int e = 0; e < 3; e++) begin
                tick();
                n_vec++;
                if (ts_out !== 1'b1 || scan_out !== 16'h0011 * 16'(e + 1)) begin
                    n_err++; $display("FAIL sticky_word%0d got ts=%b scan=%h", e, ts_out, scan_out);
                end
                if (run == 0 && e == 1) begin
                    tick();
                    passfail_in = 1'b1;
                    tick();
                    passfail_in = 1'b0;
                    n_vec++;
                    if (fail_out !== 1'b1) begin n_err++; $display("FAIL sticky_set got fail=%b want 1", fail_out); end
                end
                elem_done_in = 1'b1;
                tick();
                elem_done_in = 1'b0;
            end
            n_vec++;
            if (done_out !== 1'b1 || fail_out !== (run == 0)) begin
                n_err++; $display("FAIL sticky_done%0d got done=%b fail=%b want 1 %b", run, done_out, fail_out, run == 0);
            end
        end
        passfail_in = 1'b1;
        tick();
        passfail_in = 1'b0;
        n_vec++;
        if (fail_out !== 1'b0) begin n_err++; $display("FAIL passfail_outside_wait got fail=%b want 0", fail_out); end
    endtask

    task automatic test_abort_lockout();
        do_clear();
        load_word(16'h00AA);
        load_word(16'h00BB);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        shift_in  = 1'b1;
        sdi_in    = 1'b1;
        commit_in = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        shift_in  = 1'b0;
        sdi_in    = 1'b0;
        commit_in = 1'b0;
        n_vec++;
        if (count_out !== 4'd2 || busy_out !== 1'b1) begin
            n_err++; $display("FAIL lockout_count got cnt=%0d busy=%b want 2 1", count_out, busy_out);
        end
        do_clear();
        n_vec++;
        if (count_out !== 4'd0 || done_out !== 1'b0 || busy_out !== 1'b0 || ts_out !== 1'b0) begin
            n_err++; $display("FAIL clear_midrun got cnt=%0d done=%b busy=%b ts=%b want 0 0 0 0",
                              count_out, done_out, busy_out, ts_out);
        end
        // Commit without shifting: the stored word proves the shift register was untouched in WAIT.
        commit_in = 1'b1;
        tick();
        commit_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        n_vec++;
        if (ts_out !== 1'b1 || scan_out !== 16'h00BB) begin
            n_err++; $display("FAIL lockout_shreg got ts=%b scan=%h want ts=1 scan=00bb", ts_out, scan_out);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({scan_out, ts_out, busy_out, done_out, fail_out, count_out} !== 24'h0) begin
            n_err++; $display("FAIL async_reset got scan=%h ts=%b busy=%b done=%b fail=%b cnt=%0d want all 0",
                              scan_out, ts_out, busy_out, done_out, fail_out, count_out);
        end
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (ts_out !== 1'b0 || count_out !== 4'd0 || busy_out !== 1'b0) begin
            n_err++; $display("FAIL post_reset got ts=%b cnt=%0d busy=%b want 0 0 0", ts_out, count_out, busy_out);
        end
    endtask

`ifdef MPL_ELEM_TIMEOUT_EN
    task automatic test_timeout();
        do_clear();
        load_word(16'h5A5A);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        for (int c = 0; c < 14; c++) tick();
        n_vec++;
        if (busy_out !== 1'b1 || timeout_out !== 1'b0) begin
            n_err++; $display("FAIL timeout_early got busy=%b timeout=%b want 1 0", busy_out, timeout_out);
        end
        tick();
        n_vec++;
        if (done_out !== 1'b1 || timeout_out !== 1'b1 || fail_out !== 1'b1) begin
            n_err++; $display("FAIL timeout_fire got done=%b timeout=%b fail=%b want 1 1 1", done_out, timeout_out, fail_out);
        end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        n_vec++;
        if (timeout_out !== 1'b0 || fail_out !== 1'b0) begin
            n_err++; $display("FAIL timeout_restart got timeout=%b fail=%b want 0 0", timeout_out, fail_out);
        end
        tick();
        elem_done_in = 1'b1;
        tick();
        elem_done_in = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi_order();
        test_overflow_empty();
        test_sticky_fail();
        test_abort_lockout();
`ifdef MPL_ELEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/march_program_sequencer.md
Name: march_program_sequencer

Overview:
- Upstream feeder for the memory BIST top.
- Serially loads up to `depth` march-element scan words into a small program store.
- On start, issues each word in order on the BIST scan input with a one-cycle test-start pulse, then waits for element completion.
- Accumulates a sticky fail from the BIST pass/fail output and reports run completion.

Parameters:
- sw, 16, scan word width; must equal the BIST scan width.
- depth, 8, maximum number of march elements held.
- pw, 3, program pointer width; must satisfy 2^pw = depth.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sdi_in  in  1  serial scan data, MSB first.
- shift_in  in  1  shift enable; shifts sdi_in into the shift register.
- commit_in  in  1  writes the shift register to program slot count_out, then increments count.
- clear_in  in  1  empties the program store and returns to IDLE.
- start_in  in  1  begins a run.
- elem_done_in  in  1  one-cycle pulse from BIST logic: the current march element has finished.
- passfail_in  in  1  BIST comparator result; 1 = mismatch.
- scan_out  out  sw  current march word to the BIST scan input.
- ts_out  out  1  test-start pulse to the BIST.
- busy_out  out  1  high in ISSUE and WAIT.
- done_out  out  1  high in DONE.
- fail_out  out  1  sticky fail for the current or last run.
- count_out  out  pw+1  number of committed elements, 0..depth.

Behaviour:
- Reset (rst low, asynchronous), all registers cleared:
  - State goes to IDLE.
  - scan_out, ts_out, busy_out, done_out, fail_out and count_out are all 0.
  - Shift register and read pointer are 0.
  - Program store contents are don't-care.
- Load (accepted only in IDLE or DONE):
  - shift_in: shreg <= {shreg[sw-2:0], sdi_in}.
  - commit_in with count < depth: mem[count] <= shreg, count++. The written word includes a shift in the same cycle: if shift_in and commit_in are both high, the committed word is the post-shift value.
  - commit_in with count == depth: ignored; no write and count holds.
  - shift_in and commit_in are ignored in ISSUE and WAIT.
- clear_in:
  - In any state: count <= 0, read pointer <= 0, state <= IDLE, ts_out <= 0.
  - fail_out is kept.
  - clear_in has priority over all other inputs.
- State machine:
  - IDLE:
    - start_in with count > 0 goes to ISSUE. It also sets rd <= 0 and fail_out <= 0.
    - start_in with count == 0 goes directly to DONE with fail_out <= 0.
  - ISSUE (exactly one cycle):
    - scan_out <= mem[rd], registered.
    - ts_out is registered and asserts high in the cycle after ISSUE is entered, aligned with the first cycle scan_out shows the new word.
    - Next state is WAIT.
  - WAIT:
    - scan_out holds stable.
    - passfail_in = 1 in any WAIT cycle sets fail_out.
    - On elem_done_in:
      - If rd == count-1, go to DONE.
      - Otherwise rd++ and go to ISSUE.
    - An elem_done_in arriving on the same cycle ts_out is high is honoured.
  - DONE:
    - done_out = 1 and fail_out holds.
    - start_in re-runs exactly as from IDLE, with the program retained.
- Input qualification:
  - start_in is ignored in ISSUE and WAIT.
  - elem_done_in is ignored outside WAIT.
  - passfail_in is ignored outside WAIT.
- Latency:
  - start to first ts_out: 2 cycles.
  - elem_done_in to next ts_out: 2 cycles.
  - Final elem_done_in to done_out: 1 cycle.
- Mid-run behaviour:
  - Reset mid-run aborts immediately; ts_out is never left high.
  - clear_in mid-run aborts to IDLE with done_out low.

Optional Feature:
- Macro: MPL_ELEM_TIMEOUT_EN.
- When defined:
  - Adds parameter tw (default 12) and output timeout_out (1 bit).
  - A tw-bit watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches 2^tw-1 without elem_done_in, the block goes to DONE with fail_out <= 1 and timeout_out <= 1.
  - timeout_out is cleared by reset, clear_in and an accepted start_in.
- When undefined:
  - No counter and no port.
  - WAIT waits indefinitely.

Test Plan:
- Load and single element: shift in 0xA5C3 MSB-first (16 shifts) and commit, so count_out = 1. Pulse start. scan_out = 0xA5C3 with ts_out high 2 cycles later. Pulse elem_done_in. done_out = 1 one cycle later and fail_out = 0.
- Multi-element order: commit 0x0001, 0x0002, 0x0003 and run, ack each element 5 cycles after its ts_out. Three ts_out pulses occur with scan_out 0x0001, 0x0002, 0x0003 in order, then done_out = 1.
- Overflow and empty run:
  - Commit 9 words with depth = 8: count_out saturates at 8 and mem[7] equals the 8th word.
  - Clear, then start with count 0: done_out = 1 next cycle and ts_out is never asserted.
- Sticky fail and rerun: passfail_in = 1 for one cycle during WAIT of element 2 of 3. fail_out stays 1 through DONE. A restart with no failures clears fail_out and ends with fail_out = 0.
- Abort and lockout:
  - During WAIT, shift_in/commit_in leave count_out and the shift register unchanged.
  - rst low mid-run forces all outputs to 0 asynchronously.
  - clear_in mid-run gives IDLE with count_out = 0.
- Timeout (MPL_ELEM_TIMEOUT_EN, tw = 4): no elem_done_in after ts_out, so DONE with timeout_out = 1 and fail_out = 1 after 15 WAIT cycles.
